// File: rtl/pipelined_adder_pkg.sv
// Shared types and parameter checks for the segmented pipelined adder.
package pipelined_adder_pkg;

    localparam int MIN_STAGES = 1;

    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
    } stage_ctrl_t;

    // WIDTH must split evenly into STAGES non-empty segments.
    function automatic bit stages_legal(input int width, input int stages);
        return (stages >= MIN_STAGES) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One SEG-bit registered segment of the pipelined adder: segment sum, carry, valid and sub.
module pipelined_adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  stage_ctrl_t    ctrl_i,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    output stage_ctrl_t    ctrl_o,
    output logic [SEG-1:0] sum_o,
    output logic           ovf_o
);

    logic [SEG-1:0] b_eff;
    logic [SEG:0]   add_full;
    stage_ctrl_t    ctrl_d, ctrl_q;
    logic [SEG-1:0] sum_d, sum_q;
    logic           ovf_d, ovf_q;

    // Subtraction inverts b here; the inverted carry-in is applied once, at stage 0.
    always_comb begin
        b_eff        = ctrl_i.sub ? ~b_i : b_i;
        add_full     = {1'b0, a_i} + {1'b0, b_eff} + {{SEG{1'b0}}, ctrl_i.carry};
        sum_d        = add_full[SEG-1:0];
        ctrl_d.valid = ctrl_i.valid;
        ctrl_d.carry = add_full[SEG];
        ctrl_d.sub   = ctrl_i.sub;
        ovf_d        = (a_i[SEG-1] == b_eff[SEG-1]) && (sum_d[SEG-1] != a_i[SEG-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (load_i) begin
            ctrl_q <= ctrl_d;
            sum_q  <= sum_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign sum_o  = sum_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/pipelined_adder.sv
// Segmented pipelined adder with valid/ready handshake, carry-out and signed overflow.
// Optional subtract mode (sub port) is enabled by defining PIPELINED_ADDER_SUB_EN.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    if (!stages_legal(WIDTH, STAGES)) begin : g_illegal
        $error("pipelined_adder: WIDTH must be a positive integer multiple of STAGES");
    end

    logic              sub_w;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] valid_w;
    logic              rdy_run;

    stage_ctrl_t      ctrl_in  [STAGES];
    stage_ctrl_t      ctrl_out [STAGES];
    logic [SEG-1:0]   seg_sum  [STAGES];
    logic             seg_ovf  [STAGES];

    // opa/opb: operands entering stage k; *_sk_q: operands travelling alongside stage k.
    logic [WIDTH-1:0] opa      [STAGES];
    logic [WIDTH-1:0] opb      [STAGES];
    logic [WIDTH-1:0] a_sk_q   [STAGES];
    logic [WIDTH-1:0] b_sk_q   [STAGES];
    logic [WIDTH-1:0] low_d    [STAGES];
    logic [WIDTH-1:0] low_q    [STAGES];

`ifdef PIPELINED_ADDER_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    // A stage may load unless it and every stage after it are full and the output is stalled.
    always_comb begin
        rdy_run = out_ready;
        ready   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy_run  = !valid_w[k] || rdy_run;
            ready[k] = rdy_run;
        end
    end

    assign in_ready = ready[0];

    always_comb begin
        opa[0]           = a;
        opb[0]           = b;
        ctrl_in[0].valid = in_valid;
        ctrl_in[0].carry = cin ^ sub_w;
        ctrl_in[0].sub   = sub_w;
        low_d[0]         = '0;
        for (int k = 1; k < STAGES; k++) begin
            opa[k]                      = a_sk_q[k-1];
            opb[k]                      = b_sk_q[k-1];
            ctrl_in[k]                  = ctrl_out[k-1];
            low_d[k]                    = low_q[k-1];
            low_d[k][(k-1)*SEG +: SEG]  = seg_sum[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_sk_q[k] <= '0;
                b_sk_q[k] <= '0;
                low_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    a_sk_q[k] <= opa[k];
                    b_sk_q[k] <= opb[k];
                    low_q[k]  <= low_d[k];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipelined_adder_stage #(
            .SEG (SEG)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .load_i (ready[k]),
            .ctrl_i (ctrl_in[k]),
            .a_i    (opa[k][k*SEG +: SEG]),
            .b_i    (opb[k][k*SEG +: SEG]),
            .ctrl_o (ctrl_out[k]),
            .sum_o  (seg_sum[k]),
            .ovf_o  (seg_ovf[k])
        );
        assign valid_w[k] = ctrl_out[k].valid;
    end

    always_comb begin
        sum                          = low_q[STAGES-1];
        sum[(STAGES-1)*SEG +: SEG]   = seg_sum[STAGES-1];
        cout                         = ctrl_out[STAGES-1].carry;
        ovf                          = seg_ovf[STAGES-1];
        out_valid                    = valid_w[STAGES-1];
    end

endmodule
